sdp_erdma_eg_ro_sched: RTL
==========================

// Module: sdp_erdma_eg_ro_sched
// PURPOSE
//  Round-robin scheduler for the ERDMA egress read-order path. It arbitrates among NUM_CH
//  read-order context cfifos (4-bit pd = beats-1 per request) and pops one context entry.
//  It then streams pd+1 data beats from the granted channel onto a single shared output.
//  Sits between the per-channel RO cfifos and the SDP egress datapath.
// PARAMETERS
//  NUM_CH  4   number of requesting channels (2..8); CH_W = $clog2(NUM_CH)
//  DW      32  data beat width
// PORTS
//  nvdla_core_clk_mgated  in   1          clock
//  nvdla_core_rstn        in   1          reset
//  roc_rd_pvld            in   NUM_CH     per-channel context valid
//  roc_rd_pd              in   4*NUM_CH   per-channel context, ch k at [4k+3:4k], value = beats-1
//  roc_rd_prdy            out  NUM_CH     context pop, one-hot or zero
//  dat_pvld               in   NUM_CH     per-channel data valid
//  dat_pd                 in   DW*NUM_CH  per-channel data, ch k at [DW*k+:DW]
//  dat_prdy               out  NUM_CH     data accept, one-hot or zero
//  out_pvld               out  1          merged data valid
//  out_pd                 out  DW         merged data
//  out_ch                 out  CH_W       source channel of current beat
//  out_last               out  1          final beat of the request
//  out_prdy               in   1          downstream ready
// BEHAVIOUR
//  - Reset is nvdla_core_rstn: asynchronous, active-low. Clock is nvdla_core_clk_mgated.
//  - Reset values: state=IDLE, rr_ptr=NUM_CH-1, beat_cnt=0, gnt_ch=0.
//    All outputs are 0 out of reset: roc_rd_prdy, dat_prdy, out_pvld, out_last.
//  - FSM IDLE:
//    - If any roc_rd_pvld is set, pick the first valid ch searching rr_ptr+1, rr_ptr+2, ...
//      with modulo NUM_CH wrap.
//    - Drive roc_rd_prdy[ch]=1 combinationally in that cycle (pop).
//    - Register gnt_ch=ch, beat_cnt=roc_rd_pd[ch], rr_ptr=ch.
//    - Next state is XFER.
//    - If no roc_rd_pvld is set, stay in IDLE with all prdy=0.
//  - FSM XFER (combinational passthrough, zero latency):
//    - out_pvld = dat_pvld[gnt_ch]
//    - out_pd   = dat_pd[gnt_ch]
//    - out_ch   = gnt_ch
//    - dat_prdy[gnt_ch] = out_prdy; all other dat_prdy = 0
//    - out_last = (beat_cnt==0)
//    - roc_rd_prdy = 0
//  - Beat accept is out_pvld & out_prdy:
//    - beat_cnt != 0: decrement.
//    - beat_cnt == 0: go to IDLE.
//  - Handshake: out_pvld/out_pd/out_ch/out_last hold stable while out_pvld & !out_prdy,
//    provided the source holds dat_pvld/dat_pd.
//  - One bubble cycle (IDLE) between requests. Back-to-back throughput per request is
//    pd+2 cycles.
//  - pd=0 gives a single beat with out_last=1. pd=15 gives 16 beats; beat_cnt is 4 bits,
//    with no wrap.
//  - Fairness: a channel that was just served has lowest priority next arbitration.
//    With all channels valid, grant order is 0,1,2,3,0,...
//  - Contexts arriving in XFER are ignored until IDLE; no preemption mid-request.
//  - dat_pvld on non-granted channels has no effect.
//  - Reset mid-XFER aborts the request immediately with no partial state retained.
//    rr_ptr returns to NUM_CH-1.
// CONFIGURATION
//  Macro SDP_ERDMA_RO_SCHED_PERF_EN. When defined, it adds the following ports:
//    perf_clr        in   1   synchronous clear
//    perf_stall_cnt  out  32  stall counter
//  - perf_stall_cnt counts cycles in XFER with dat_pvld[gnt_ch] & !out_prdy.
//  - The counter saturates at 32'hFFFF_FFFF, resets to 0, and perf_clr has priority
//    over increment.
//  When not defined: the ports are absent, no counter logic is built, and the remaining
//  behaviour is identical.
// TESTING
//  1. Single request, ch2 pd=3, data always valid, out_prdy=1:
//     -> roc_rd_prdy=4'b0100 for 1 cycle, then 4 beats with out_ch=2 and out_last
//        on the 4th only.
//  2. All 4 channels valid, pd=0 each:
//     -> grants in order 0,1,2,3,0. Each request takes 2 cycles (IDLE pop + 1 beat).
//  3. Backpressure: ch1 pd=1, out_prdy low for 3 cycles on beat 0:
//     -> out_pd/out_last held stable, beat_cnt unchanged.
//     -> with PERF_EN, perf_stall_cnt=3.
//  4. Boundary: ch0 pd=15 -> exactly 16 beats, then IDLE.
//     ch3 pd=0 -> exactly 1 beat, out_last=1.
//  5. Reset mid-request: assert rstn low during beat 2 of a pd=7 request:
//     -> all outputs 0 immediately. After release, ch0 wins when ch0 and ch1 are
//        both valid.
//  6. Data gap: granted ch has dat_pvld=0 for 2 cycles:
//     -> out_pvld=0, no count change, request completes afterward.
//     -> with PERF_EN, perf_stall_cnt unchanged.

Source files
------------

// File: rtl/sdp_erdma_eg_ro_sched.sv
// Round-robin read-order scheduler: pops one context from NUM_CH RO cfifos, then streams pd+1 data beats.
// Optional stall counter built when SDP_ERDMA_RO_SCHED_PERF_EN is defined.
module sdp_erdma_eg_ro_sched #(
    parameter  int NUM_CH = 4,
    parameter  int DW     = 32,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic                 nvdla_core_clk_mgated,
    input  logic                 nvdla_core_rstn,
    input  logic [NUM_CH-1:0]    roc_rd_pvld,
    input  logic [4*NUM_CH-1:0]  roc_rd_pd,
    output logic [NUM_CH-1:0]    roc_rd_prdy,
    input  logic [NUM_CH-1:0]    dat_pvld,
    input  logic [DW*NUM_CH-1:0] dat_pd,
    output logic [NUM_CH-1:0]    dat_prdy,
    output logic                 out_pvld,
    output logic [DW-1:0]        out_pd,
    output logic [CH_W-1:0]      out_ch,
    output logic                 out_last,
    input  logic                 out_prdy
`ifdef SDP_ERDMA_RO_SCHED_PERF_EN
    ,
    input  logic                 perf_clr,
    output logic [31:0]          perf_stall_cnt
`endif
);

    typedef enum logic {IDLE, XFER} state_e;

    state_e          state_q, state_d;
    logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0] gnt_ch_q, gnt_ch_d;
    logic [3:0]      beat_cnt_q, beat_cnt_d;

    logic            arb_found;
    logic [CH_W-1:0] arb_pick;

    // Search starts one past the last served channel, so it ends up lowest priority.
    always_comb begin
        int idx;
        arb_found = 1'b0;
        arb_pick  = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = (int'(rr_ptr_q) + i) % NUM_CH;
            if (!arb_found && roc_rd_pvld[idx]) begin
                arb_found = 1'b1;
                arb_pick  = CH_W'(idx);
            end
        end
    end

    always_comb begin
        // NOTE: every output and next-state gets a default first; any path that skipped one would infer a latch.
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_ch_d    = gnt_ch_q;
        beat_cnt_d  = beat_cnt_q;
        roc_rd_prdy = '0;
        dat_prdy    = '0;
        out_pvld    = 1'b0;
        out_pd      = '0;
        out_ch      = gnt_ch_q;
        out_last    = 1'b0;

        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    // Pop is suppressed while reset is held so no context is lost to a scheduler in reset.
                    roc_rd_prdy[arb_pick] = nvdla_core_rstn;
                    gnt_ch_d              = arb_pick;
                    rr_ptr_d              = arb_pick;
                    beat_cnt_d            = roc_rd_pd[4*arb_pick +: 4];
                    state_d               = XFER;
                end
            end
            XFER: begin
                out_pvld           = dat_pvld[gnt_ch_q];
                out_pd             = dat_pd[DW*gnt_ch_q +: DW];
                out_last           = (beat_cnt_q == 4'd0);
                dat_prdy[gnt_ch_q] = out_prdy;
                if (out_pvld && out_prdy) begin
                    if (beat_cnt_q == 4'd0) begin
                        state_d = IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q - 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge nvdla_core_clk_mgated or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q    <= IDLE;
            rr_ptr_q   <= CH_W'(NUM_CH - 1);
            gnt_ch_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_ch_q   <= gnt_ch_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

`ifdef SDP_ERDMA_RO_SCHED_PERF_EN
    logic        stall;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // A stall is a beat that is ready to go but blocked downstream; data gaps do not count.
    assign stall = (state_q == XFER) && dat_pvld[gnt_ch_q] && !out_prdy;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (perf_clr) begin
            stall_cnt_d = '0;
        end else if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge nvdla_core_clk_mgated or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule
